sdram_slot_arb: RTL and testbench

//  Two-channel arbiter between the cartridge-slot SDRAM request ports and the single

---
 rtl/sdram_slot_arb_if.sv | 30 +++
 rtl/sdram_slot_arb.sv | 139 +++++++++++++
 tb/tb_sdram_slot_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_slot_arb_if.sv
// Signal bundle between the two cartridge-slot request channels, the arbiter
// and the single byte-wide SDRAM controller port.
interface sdram_slot_arb_if #(
    parameter int AW = 25
);
    logic [1:0][AW-1:0] ch_addr;
    logic [1:0][7:0]    ch_din;
    logic [1:0]         ch_we;
    logic [1:0]         ch_rd;
    logic [1:0][7:0]    ch_dout;
    logic [1:0]         ch_ready;
    logic [AW-1:0]      mem_addr;
    logic [7:0]         mem_din;
    logic               mem_we;
    logic               mem_rd;
    logic [7:0]         mem_dout;
    logic               mem_ack;
    logic               timeout_err;

    // slave is the arbiter's view; master is the view of the environment around it
    modport slave (
        input  ch_addr, ch_din, ch_we, ch_rd, mem_dout, mem_ack,
        output ch_dout, ch_ready, mem_addr, mem_din, mem_we, mem_rd, timeout_err
    );

    modport master (
        output ch_addr, ch_din, ch_we, ch_rd, mem_dout, mem_ack,
        input  ch_dout, ch_ready, mem_addr, mem_din, mem_we, mem_rd, timeout_err
    );
endinterface

// File: rtl/sdram_slot_arb.sv
// Round-robin arbiter from two slot request channels (ch0 = slot B, ch1 = slot A)
// onto one SDRAM controller port, with a watchdog that completes ops the controller drops.
module sdram_slot_arb #(
    parameter int AW      = 25,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    sdram_slot_arb_if.slave   io_bus
);
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t              r_state;
    logic [1:0]          r_lvlPrev;
    logic [1:0][AW-1:0]  r_addrPrev;
    logic [1:0][AW-1:0]  r_snapAddr;
    logic [1:0][7:0]     r_snapDin;
    logic [1:0]          r_snapWe;
    logic [1:0]          r_pending;
    logic [1:0]          r_ready;
    logic [1:0][7:0]     r_dout;
    logic                r_grant;
    logic                r_lastGrant;
    logic [WDW-1:0]      r_watchdog;
    logic [AW-1:0]       r_memAddr;
    logic [7:0]          r_memDin;
    logic                r_memWe;
    logic                r_memRd;
    logic                r_timeoutErr;

    logic [1:0]          w_reqLvl;
    logic [1:0]          w_trigger;
    logic [1:0]          w_capture;
    logic [1:0][AW-1:0]  w_nextAddr;
    logic [1:0][7:0]     w_nextDin;
    logic [1:0]          w_nextWe;
    logic                w_pick;
    logic                w_wdExpired;

    // A channel's snapshot is frozen once it owns the memory port; the w_next* values
    // let a grant in the same cycle as a fresh trigger issue the newest request.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_reqLvl[n]   = io_bus.ch_we[n] | io_bus.ch_rd[n];
            w_trigger[n]  = w_reqLvl[n] & (~r_lvlPrev[n] | (io_bus.ch_addr[n] != r_addrPrev[n]));
            w_capture[n]  = w_trigger[n] & ~((r_state != IDLE) & (r_grant == 1'(n)));
            w_nextAddr[n] = w_capture[n] ? io_bus.ch_addr[n] : r_snapAddr[n];
            w_nextDin[n]  = w_capture[n] ? io_bus.ch_din[n]  : r_snapDin[n];
            w_nextWe[n]   = w_capture[n] ? io_bus.ch_we[n]   : r_snapWe[n];
        end
        w_pick      = (r_pending == 2'b11) ? ~r_lastGrant : r_pending[1];
        w_wdExpired = (r_watchdog == WDW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lvlPrev    <= '0;
            r_addrPrev   <= '0;
            r_snapAddr   <= '0;
            r_snapDin    <= '0;
            r_snapWe     <= '0;
            r_pending    <= '0;
            r_ready      <= 2'b11;
            r_dout       <= {8'hFF, 8'hFF};
            r_grant      <= 1'b0;
            r_lastGrant  <= 1'b1;
            r_watchdog   <= '0;
            r_memAddr    <= '0;
            r_memDin     <= '0;
            r_memWe      <= 1'b0;
            r_memRd      <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_lvlPrev  <= w_reqLvl;
            r_addrPrev <= io_bus.ch_addr;
            r_memWe    <= 1'b0;
            r_memRd    <= 1'b0;

            for (int n = 0; n < 2; n++) begin
                if (w_capture[n]) begin
                    r_snapAddr[n] <= io_bus.ch_addr[n];
                    r_snapDin[n]  <= io_bus.ch_din[n];
                    r_snapWe[n]   <= io_bus.ch_we[n];
                    r_pending[n]  <= 1'b1;
                    r_ready[n]    <= 1'b0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_grant   <= w_pick;
                        r_memAddr <= w_nextAddr[w_pick];
                        r_memDin  <= w_nextDin[w_pick];
                        r_memWe   <= w_nextWe[w_pick];
                        r_memRd   <= ~w_nextWe[w_pick];
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_watchdog <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (io_bus.mem_ack || w_wdExpired) begin
                        if (!r_snapWe[r_grant]) begin
                            r_dout[r_grant] <= io_bus.mem_ack ? io_bus.mem_dout : 8'hFF;
                        end
                        if (!io_bus.mem_ack) begin
                            r_timeoutErr <= 1'b1;
                        end
                        r_pending[r_grant] <= 1'b0;
                        r_ready[r_grant]   <= 1'b1;
                        r_lastGrant        <= r_grant;
                        r_state            <= IDLE;
                    end else begin
                        r_watchdog <= r_watchdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.ch_dout     = r_dout;
    assign io_bus.ch_ready    = r_ready;
    assign io_bus.mem_addr    = r_memAddr;
    assign io_bus.mem_din     = r_memDin;
    assign io_bus.mem_we      = r_memWe;
    assign io_bus.mem_rd      = r_memRd;
    assign io_bus.timeout_err = r_timeoutErr;
endmodule

// File: tb/tb_sdram_slot_arb.sv
// Bench for sdram_slot_arb: directed scenarios plus randomized traffic, all outputs
// compared each cycle against a transaction-level model of the arbiter.
module tb_sdram_slot_arb;
    localparam int AW  = 25;
    localparam int TMO = 8;

    logic clk;
    logic reset;

    sdram_slot_arb_if #(.AW(AW)) bus ();

    sdram_slot_arb #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: pending flags, request snapshots, and which channel owns the port
    bit           modelValid = 0;
    bit           mPend [2];
    bit           mPrevLvl [2];
    logic [AW-1:0] mPrevAddr [2];
    logic [AW-1:0] mSnapAddr [2];
    logic [7:0]   mSnapDin [2];
    bit           mSnapWe [2];
    int           mOwner = -1;
    int           mAge = 0;
    int           mLast = 1;
    logic [7:0]   eDout [2];
    logic [AW-1:0] eMemAddr;
    logic [7:0]   eMemDin;
    bit           eWe, eRd, eErr;

    // Controller responder state
    bit           randomMode = 0;
    bit           noAck = 0;
    int           ackDelay = 2;
    int           ackCount = 0;
    logic [7:0]   ackData = 8'h00;
    int           strobeCount = 0;
    logic [AW-1:0] strobeAddrs [$];

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic modelStep();
        bit   trig [2];
        bit   oldPend [2];
        bit   lvl;
        int   oldOwner;
        int   g;
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                mPend[n]     = 0;
                mPrevLvl[n]  = 0;
                mPrevAddr[n] = '0;
                mSnapAddr[n] = '0;
                mSnapDin[n]  = '0;
                mSnapWe[n]   = 0;
                eDout[n]     = 8'hFF;
            end
            mOwner = -1; mAge = 0; mLast = 1;
            eMemAddr = '0; eMemDin = '0; eWe = 0; eRd = 0; eErr = 0;
            modelValid = 1;
            return;
        end
        oldOwner = mOwner;
        for (int n = 0; n < 2; n++) begin
            oldPend[n] = mPend[n];
            lvl = bus.ch_we[n] | bus.ch_rd[n];
            trig[n] = lvl && (!mPrevLvl[n] || bus.ch_addr[n] != mPrevAddr[n]);
            mPrevLvl[n]  = lvl;
            mPrevAddr[n] = bus.ch_addr[n];
            if (trig[n] && oldOwner != n) begin
                mPend[n]     = 1;
                mSnapAddr[n] = bus.ch_addr[n];
                mSnapDin[n]  = bus.ch_din[n];
                mSnapWe[n]   = bus.ch_we[n];
            end
        end
        eWe = 0;
        eRd = 0;
        if (oldOwner < 0) begin
            if (oldPend[0] || oldPend[1]) begin
                if (oldPend[0] && oldPend[1]) g = 1 - mLast;
                else g = oldPend[0] ? 0 : 1;
                mOwner = g;
                mAge = 0;
                eMemAddr = mSnapAddr[g];
                eMemDin  = mSnapDin[g];
                eWe = mSnapWe[g];
                eRd = !mSnapWe[g];
            end
        end else if (mAge >= 1 && (bus.mem_ack || mAge == TMO)) begin
            if (!mSnapWe[oldOwner]) eDout[oldOwner] = bus.mem_ack ? bus.mem_dout : 8'hFF;
            if (!bus.mem_ack) eErr = 1;
            mPend[oldOwner] = 0;
            mLast = oldOwner;
            mOwner = -1;
        end else begin
            mAge++;
        end
    endtask

    task automatic checkOutput();
        for (int n = 0; n < 2; n++) begin
            checkVal($sformatf("ch_ready[%0d]", n), 32'(bus.ch_ready[n]), 32'(!mPend[n]));
            checkVal($sformatf("ch_dout[%0d]", n), 32'(bus.ch_dout[n]), 32'(eDout[n]));
        end
        checkVal("mem_we", 32'(bus.mem_we), 32'(eWe));
        checkVal("mem_rd", 32'(bus.mem_rd), 32'(eRd));
        checkVal("mem_addr", 32'(bus.mem_addr), 32'(eMemAddr));
        checkVal("mem_din", 32'(bus.mem_din), 32'(eMemDin));
        checkVal("timeout_err", 32'(bus.timeout_err), 32'(eErr));
    endtask

    // Drives mem_ack/mem_dout for the current cycle and schedules acks after strobes
    task automatic respond();
        if (ackCount > 0) begin
            ackCount--;
            bus.mem_ack = (ackCount == 0);
        end else begin
            bus.mem_ack = randomMode && ($urandom_range(0, 29) == 0);
        end
        bus.mem_dout = randomMode ? 8'($urandom) : ackData;
        if (bus.mem_rd || bus.mem_we) begin
            strobeCount++;
            strobeAddrs.push_back(bus.mem_addr);
            if (randomMode) begin
                noAck = ($urandom_range(0, 7) == 0);
                ackDelay = $urandom_range(1, 10);
            end
            if (!noAck) ackCount = ackDelay;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        if (modelValid) checkOutput();
        respond();
    endtask

    task automatic applyStimulus(input int ch, input bit rd, input bit we, input logic [AW-1:0] addr, input logic [7:0] din);
        bus.ch_rd[ch]   = rd;
        bus.ch_we[ch]   = we;
        bus.ch_addr[ch] = addr;
        bus.ch_din[ch]  = din;
    endtask

    task automatic waitReady(input int ch, input int budget);
        int k = 0;
        while (!bus.ch_ready[ch] && k < budget) begin
            cycle();
            k++;
        end
        checkVal($sformatf("waitReady ch%0d", ch), 32'(bus.ch_ready[ch]), 32'd1);
    endtask

    task automatic runUntilStrobes(input int want, input int budget);
        int k = 0;
        while (strobeAddrs.size() < want && k < budget) begin
            cycle();
            k++;
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        bus.ch_addr  = '0;
        bus.ch_din   = '0;
        bus.ch_we    = '0;
        bus.ch_rd    = '0;
        bus.mem_dout = '0;
        bus.mem_ack  = 1'b0;
        reset        = 1'b1;

        resetDut();
        checkVal("reset ready", 32'(bus.ch_ready), 32'h3);
        checkVal("reset dout0", 32'(bus.ch_dout[0]), 32'hFF);
        checkVal("reset dout1", 32'(bus.ch_dout[1]), 32'hFF);
        checkVal("reset err", 32'(bus.timeout_err), 32'h0);

        $display("[TB] test 1: ch1 read");
        ackDelay = 3; noAck = 0; ackData = 8'h5A;
        applyStimulus(1, 1, 0, 25'h0123456, 8'h00);
        cycle();
        checkVal("t1 ready low", 32'(bus.ch_ready[1]), 32'h0);
        checkVal("t1 no early rd", 32'(bus.mem_rd), 32'h0);
        cycle();
        checkVal("t1 rd strobe", 32'(bus.mem_rd), 32'h1);
        checkVal("t1 addr", 32'(bus.mem_addr), 32'h0123456);
        cycle();
        checkVal("t1 rd width", 32'(bus.mem_rd), 32'h0);
        cycle();
        cycle();
        checkVal("t1 ready at ack", 32'(bus.ch_ready[1]), 32'h0);
        cycle();
        checkVal("t1 ready after ack", 32'(bus.ch_ready[1]), 32'h1);
        checkVal("t1 dout", 32'(bus.ch_dout[1]), 32'h5A);
        applyStimulus(1, 0, 0, 25'h0123456, 8'h00);
        cycle();

        $display("[TB] test 2: ch0 write");
        ackDelay = 2; ackData = 8'hC3;
        applyStimulus(0, 0, 1, 25'h0000010, 8'h77);
        cycle();
        cycle();
        checkVal("t2 we strobe", 32'(bus.mem_we), 32'h1);
        checkVal("t2 no rd", 32'(bus.mem_rd), 32'h0);
        checkVal("t2 din", 32'(bus.mem_din), 32'h77);
        checkVal("t2 addr", 32'(bus.mem_addr), 32'h10);
        cycle();
        checkVal("t2 we width", 32'(bus.mem_we), 32'h0);
        cycle();
        cycle();
        checkVal("t2 ready", 32'(bus.ch_ready[0]), 32'h1);
        checkVal("t2 dout kept", 32'(bus.ch_dout[0]), 32'hFF);
        applyStimulus(0, 0, 0, 25'h0000010, 8'h00);
        cycle();

        $display("[TB] test 3: round robin");
        resetDut();
        ackDelay = 2; ackData = 8'h3C;
        strobeAddrs.delete();
        applyStimulus(0, 1, 0, 25'h200, 8'h00);
        applyStimulus(1, 1, 0, 25'h300, 8'h00);
        runUntilStrobes(2, 30);
        checkVal("t3a strobes", 32'(strobeAddrs.size()), 32'd2);
        if (strobeAddrs.size() >= 2) begin
            checkVal("t3a first", 32'(strobeAddrs[0]), 32'h200);
            checkVal("t3a second", 32'(strobeAddrs[1]), 32'h300);
        end
        waitReady(0, 20);
        waitReady(1, 20);
        checkVal("t3a dout0", 32'(bus.ch_dout[0]), 32'h3C);
        bus.ch_rd = 2'b00;
        cycle();
        applyStimulus(0, 1, 0, 25'h210, 8'h00);
        cycle();
        cycle();
        waitReady(0, 20);
        bus.ch_rd = 2'b00;
        cycle();
        strobeAddrs.delete();
        applyStimulus(0, 1, 0, 25'h220, 8'h00);
        applyStimulus(1, 1, 0, 25'h320, 8'h00);
        runUntilStrobes(2, 30);
        checkVal("t3b strobes", 32'(strobeAddrs.size()), 32'd2);
        if (strobeAddrs.size() >= 2) begin
            checkVal("t3b first", 32'(strobeAddrs[0]), 32'h320);
            checkVal("t3b second", 32'(strobeAddrs[1]), 32'h220);
        end
        waitReady(0, 20);
        waitReady(1, 20);
        bus.ch_rd = 2'b00;
        cycle();

        $display("[TB] test 4: watchdog");
        noAck = 1;
        applyStimulus(0, 1, 0, 25'h400, 8'h00);
        for (int i = 0; i < 10; i++) cycle();
        checkVal("t4 ready before expiry", 32'(bus.ch_ready[0]), 32'h0);
        checkVal("t4 err before expiry", 32'(bus.timeout_err), 32'h0);
        cycle();
        checkVal("t4 ready at expiry", 32'(bus.ch_ready[0]), 32'h1);
        checkVal("t4 dout", 32'(bus.ch_dout[0]), 32'hFF);
        checkVal("t4 err", 32'(bus.timeout_err), 32'h1);
        applyStimulus(0, 0, 0, 25'h400, 8'h00);
        for (int i = 0; i < 5; i++) cycle();
        checkVal("t4 err sticky", 32'(bus.timeout_err), 32'h1);

        $display("[TB] test 5: address stepping");
        noAck = 0; ackDelay = 2;
        strobeCount = 0;
        for (int s = 0; s < 3; s++) begin
            ackData = 8'(8'h11 * (s + 1));
            applyStimulus(1, 1, 0, AW'(25'h100 + s), 8'h00);
            cycle();
            cycle();
            waitReady(1, 20);
            for (int i = 0; i < 4; i++) cycle();
            checkVal("t5 dout", 32'(bus.ch_dout[1]), 32'(ackData));
        end
        checkVal("t5 strobes", 32'(strobeCount), 32'd3);
        applyStimulus(1, 0, 0, 25'h102, 8'h00);
        cycle();

        $display("[TB] test 6: reset during wait");
        ackDelay = 4; ackData = 8'h99;
        applyStimulus(0, 1, 0, 25'h500, 8'h00);
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        bus.ch_rd = 2'b00;
        cycle();
        reset = 1'b0;
        checkVal("t6 ready", 32'(bus.ch_ready), 32'h3);
        checkVal("t6 dout1", 32'(bus.ch_dout[1]), 32'hFF);
        checkVal("t6 mem_addr", 32'(bus.mem_addr), 32'h0);
        checkVal("t6 err", 32'(bus.timeout_err), 32'h0);
        for (int i = 0; i < 4; i++) cycle();
        checkVal("t6 dout0 after ack", 32'(bus.ch_dout[0]), 32'hFF);
        checkVal("t6 ready after ack", 32'(bus.ch_ready), 32'h3);

        $display("[TB] random traffic");
        randomMode = 1;
        for (int i = 0; i < 3000; i++) begin
            int kind;
            reset = ($urandom_range(0, 399) == 0);
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 5) == 0) begin
                    kind = $urandom_range(0, 3);
                    bus.ch_rd[n] = kind[0];
                    bus.ch_we[n] = kind[1];
                end
                if ($urandom_range(0, 7) == 0) bus.ch_addr[n] = AW'(25'h100 + $urandom_range(0, 3));
                bus.ch_din[n] = 8'($urandom);
            end
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
